// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard, the forwarding unit and the hazard unit:
// register-address width and type, default sizes, and the pending-counter ceiling.
package reg_scoreboard_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int NUM_REGS_DEF = 32;
    localparam int CNT_W_DEF    = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Largest number of outstanding writes a cnt_w-bit counter can record.
    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// ID-stage issue and MEM/WB retire bundle between the pipeline (master) and the scoreboard (slave).
interface reg_scoreboard_if;
    import reg_scoreboard_pkg::*;

    // stall is an inverted ready: the ID instruction is taken on a rising edge
    // exactly when issue_valid & !flush & !stall; a flushed instruction is never taken.
    logic      issue_valid;
    logic      issue_regwrite;
    reg_addr_t issue_rd;
    reg_addr_t issue_rs1;
    reg_addr_t issue_rs2;
    logic      issue_use_rs1;
    logic      issue_use_rs2;
    logic      flush;
    logic      wb_valid;
    reg_addr_t wb_rd;
    logic      stall;

    modport master (
        output issue_valid, issue_regwrite, issue_rd, issue_rs1, issue_rs2,
        output issue_use_rs1, issue_use_rs2, flush, wb_valid, wb_rd,
        input  stall
    );

    modport slave (
        input  issue_valid, issue_regwrite, issue_rd, issue_rs1, issue_rs2,
        input  issue_use_rs1, issue_use_rs2, flush, wb_valid, wb_rd,
        output stall
    );

endinterface

// File: rtl/reg_scoreboard_entry.sv
// One register's pending-write counter with a sticky underflow flag.
module reg_scoreboard_entry
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Simultaneous inc and dec cancel, even at zero, so neither branch fires.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (inc_i && !dec_i) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) err_d = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = err_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Pending long-latency write tracker raising the ID-stage stall.
// Optional stall statistics counter enabled by defining REG_SCOREBOARD_STATS_EN.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    reg_scoreboard_if.slave    id_if,
`ifdef REG_SCOREBOARD_STATS_EN
    output logic [31:0]        stall_cnt_o,
`endif
    output logic               busy_o,
    output logic               err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0]    cnt [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] inc;
    logic [NUM_REGS-1:1] dec;
    logic [NUM_REGS-1:1] ent_err;
    logic [NUM_REGS-1:1] nonzero;
    logic [CNT_W-1:0]    cnt_rs1, cnt_rs2, cnt_rd;
    logic                raw, full, stall, accept;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        reg_scoreboard_entry #(.CNT_W(CNT_W)) u_entry (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .inc_i (inc[r]),
            .dec_i (dec[r]),
            .cnt_o (cnt[r]),
            .err_o (ent_err[r])
        );
    end

    // x0 has no entry, so its lookups stay at zero and it can never stall.
    always_comb begin
        cnt_rs1 = '0;
        cnt_rs2 = '0;
        cnt_rd  = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (id_if.issue_rs1 == reg_addr_t'(r)) cnt_rs1 = cnt[r];
            if (id_if.issue_rs2 == reg_addr_t'(r)) cnt_rs2 = cnt[r];
            if (id_if.issue_rd  == reg_addr_t'(r)) cnt_rd  = cnt[r];
        end
    end

    assign raw    = (id_if.issue_use_rs1 && (cnt_rs1 != '0)) ||
                    (id_if.issue_use_rs2 && (cnt_rs2 != '0));
    assign full   = id_if.issue_regwrite && (cnt_rd == CNT_MAX);
    assign stall  = id_if.issue_valid && !id_if.flush && (raw || full);
    assign accept = id_if.issue_valid && !id_if.flush && !stall &&
                    id_if.issue_regwrite && (id_if.issue_rd != '0);

    always_comb begin
        inc     = '0;
        dec     = '0;
        nonzero = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc[r]     = accept && (id_if.issue_rd == reg_addr_t'(r));
            dec[r]     = id_if.wb_valid && (id_if.wb_rd == reg_addr_t'(r));
            nonzero[r] = (cnt[r] != '0);
        end
    end

    assign id_if.stall = stall;
    assign busy_o      = |nonzero;
    assign err_o       = |ent_err;

`ifdef REG_SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized and directed bench for reg_scoreboard against a pending-count model.
// Also covers the stall counter when REG_SCOREBOARD_STATS_EN is defined.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  localparam int NREG = 32;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_scoreboard_if sb_if();
  logic busy, err;
`ifdef REG_SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt;
`endif

  reg_scoreboard #(.NUM_REGS(NREG), .CNT_W(CW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .id_if       (sb_if),
`ifdef REG_SCOREBOARD_STATS_EN
    .stall_cnt_o (stall_cnt),
`endif
    .busy_o      (busy),
    .err_o       (err)
  );

  // ---------------- scoreboard / model ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_cnt[NREG];
  bit          m_err;
  int unsigned m_stall_cnt;
  logic [0:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_err       = 1'b0;
    m_stall_cnt = 0;
  endtask

  function automatic bit model_busy();
    foreach (m_cnt[i]) if (m_cnt[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_stall();
    bit raw, full;
    raw  = (sb_if.issue_use_rs1 && sb_if.issue_rs1 != 0 && m_cnt[sb_if.issue_rs1] > 0) ||
           (sb_if.issue_use_rs2 && sb_if.issue_rs2 != 0 && m_cnt[sb_if.issue_rs2] > 0);
    full = sb_if.issue_regwrite && sb_if.issue_rd != 0 && m_cnt[sb_if.issue_rd] == CMAX;
    return sb_if.issue_valid && !sb_if.flush && (raw || full);
  endfunction

  // Net change per register this edge; a negative result at zero is an underflow.
  task automatic model_update(input bit st);
    int delta[NREG];
    int n;
    foreach (delta[i]) delta[i] = 0;
    if (sb_if.issue_valid && !sb_if.flush && !st && sb_if.issue_regwrite && sb_if.issue_rd != 0)
      delta[sb_if.issue_rd] += 1;
    if (sb_if.wb_valid && sb_if.wb_rd != 0)
      delta[sb_if.wb_rd] -= 1;
    for (int i = 0; i < NREG; i++) begin
      n = m_cnt[i] + delta[i];
      if (n < 0) begin
        n = 0;
        m_err = 1'b1;
      end
      m_cnt[i] = n;
    end
    if (st && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input bit rw, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2, input bit fl,
                       input bit wv, input logic [4:0] wrd);
    sb_if.issue_valid    = v;
    sb_if.issue_regwrite = rw;
    sb_if.issue_rd       = rd;
    sb_if.issue_rs1      = rs1;
    sb_if.issue_rs2      = rs2;
    sb_if.issue_use_rs1  = u1;
    sb_if.issue_use_rs2  = u2;
    sb_if.flush          = fl;
    sb_if.wb_valid       = wv;
    sb_if.wb_rd          = wrd;
  endtask

  // One clock: drive after the falling edge, check mid-low phase, update model at the rising edge.
  task automatic cycle(input string tag, input bit v, input bit rw, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2, input bit fl,
                       input bit wv, input logic [4:0] wrd, input int want_stall);
    bit st;
    @(negedge clk);
    drive(v, rw, rd, rs1, rs2, u1, u2, fl, wv, wrd);
    #1;
    st = model_stall();
    exp_q.push_back(st);
    check({tag, "_stall"}, {31'd0, sb_if.stall}, {31'd0, exp_q.pop_front()});
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, model_busy()});
    check({tag, "_err"}, {31'd0, err}, {31'd0, m_err});
`ifdef REG_SCOREBOARD_STATS_EN
    check({tag, "_stall_cnt"}, stall_cnt, m_stall_cnt);
`endif
    if (want_stall >= 0) check({tag, "_stall_fixed"}, {31'd0, sb_if.stall}, want_stall[31:0]);
    @(posedge clk);
    model_update(st);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("rst_stall", {31'd0, sb_if.stall}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] rd, rs1, rs2, wrd;
    bit         wv;
    int         pick;

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    #1;
    check("init_busy", {31'd0, busy}, 32'd0);
    check("init_err", {31'd0, err}, 32'd0);
    check("init_stall", {31'd0, sb_if.stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Load to x5, dependent read, retire in the stalled cycle, release the next.
    cycle("raw_issue", 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("raw_dep", 1, 0, 0, 5, 0, 1, 0, 0, 0, 0, 1);
    cycle("raw_wb", 1, 0, 0, 5, 0, 1, 0, 0, 1, 5, 1);
    cycle("raw_free", 1, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0);
    idle("raw_idle", 1);

    // x0 is never tracked.
    cycle("x0_issue", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("x0_read", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle("x0_idle", 1);

    // Fill x7 to capacity, then free one slot.
    do_reset();
    for (int i = 0; i < CMAX; i++) cycle("full_fill", 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("full_hold", 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle("full_wb", 1, 1, 7, 0, 0, 0, 0, 0, 1, 7, 1);
    cycle("full_take", 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("full_again", 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < CMAX; i++) cycle("full_drain", 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, -1);
    idle("full_idle", 1);

    // Same-cycle issue and retire; flush squashes the issue.
    do_reset();
    cycle("same_first", 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("same_both", 1, 1, 9, 0, 0, 0, 0, 0, 1, 9, 0);
    cycle("same_flush", 1, 1, 9, 9, 0, 1, 0, 1, 1, 9, 0);
    idle("same_idle", 1);

    // Underflow is sticky; asynchronous reset mid-cycle clears everything.
    cycle("uf_wb", 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, -1);
    idle("uf_hold", 3);
    cycle("uf_issue", 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 4, 0, 1, 0, 0, 0, 0);
    #1;
    check("async_pre_stall", {31'd0, sb_if.stall}, 32'd1);
    check("async_pre_err", {31'd0, err}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_stall", {31'd0, sb_if.stall}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    idle("post_rst", 1);

`ifdef REG_SCOREBOARD_STATS_EN
    cycle("stats_issue", 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle("stats_stall", 1, 0, 0, 5, 0, 1, 0, 0, 0, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("stats_four", stall_cnt, 32'd4);
    @(posedge clk);
    do_reset();
`endif

    // Randomized traffic on a small register window; retires only target pending registers.
    for (int n = 0; n < 600; n++) begin
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      wv  = 1'b0;
      wrd = '0;
      if ($urandom_range(0, 9) < 5) begin
        pick = $urandom_range(1, 7);
        for (int k = 0; k < 7; k++) begin
          if (!wv && m_cnt[((pick + k - 1) % 7) + 1] > 0) begin
            wv  = 1'b1;
            wrd = 5'(((pick + k - 1) % 7) + 1);
          end
        end
      end
      cycle("rand", 1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)), rd, rs1, rs2,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0), wv, wrd, -1);
    end
    idle("tail", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
